// File: rtl/dmi_mux_rr.sv
// dmi_mux_rr: N-channel round-robin DMI request multiplexer.
// Forwards one upstream request per cycle to a single DM port, records the
// issuing channel in an in-order ID FIFO and steers each DM response back
// to that channel. Outstanding requests are bounded by MAX_OUT.
module dmi_mux_rr #(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 34,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_CH-1:0]                     up_req_valid,
    output logic [N_CH-1:0]                     up_req_ready,
    input  logic [N_CH*(ADDR_W+DATA_W+2)-1:0]   up_req_bits,
    output logic [N_CH-1:0]                     up_resp_valid,
    input  logic [N_CH-1:0]                     up_resp_ready,
    output logic [DATA_W+1:0]                   up_resp_bits,
    output logic                                dn_req_valid,
    input  logic                                dn_req_ready,
    output logic [ADDR_W+DATA_W+1:0]            dn_req_bits,
    input  logic                                dn_resp_valid,
    output logic                                dn_resp_ready,
    input  logic [DATA_W+1:0]                   dn_resp_bits,
    output logic [$clog2(MAX_OUT+1)-1:0]        outstanding,
    output logic                                err_orphan_resp
);

    localparam int unsigned REQ_W = ADDR_W + DATA_W + 2;
    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    typedef enum logic {
        ST_FREE,
        ST_LOCK
    } lock_state_t;

    lock_state_t        r_state;
    lock_state_t        w_state_nxt;
    logic [IDX_W-1:0]   r_lock_idx;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_fifo [MAX_OUT];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               r_err;

    logic [REQ_W-1:0]   w_req_arr [N_CH];
    logic [IDX_W-1:0]   w_grant;
    logic [IDX_W-1:0]   w_idx;
    logic               w_found;
    logic               w_full;
    logic               w_empty;
    logic               w_elig;
    logic               w_push;
    logic               w_pop;
    logic               w_orphan;
    logic               w_lock_set;
    logic [IDX_W-1:0]   w_head_ch;

    // Pointer increment that wraps at MAX_OUT even when MAX_OUT is 1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Unpack the flat per-channel request bus into an indexable array.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
        assign w_req_arr[gi] = up_req_bits[gi*REQ_W +: REQ_W];
    end

    assign w_full    = (r_count == CNT_W'(MAX_OUT));
    assign w_empty   = (r_count == '0);
    assign w_elig    = ~w_full;
    assign w_head_ch = r_fifo[r_head];

    // Grant selection: locked channel if a stalled request is pending,
    // otherwise the first valid channel at or after the round-robin pointer.
    always_comb begin
        w_grant = r_rr_ptr;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            w_idx = IDX_W'((32'(r_rr_ptr) + k) % N_CH);
            if (!w_found && up_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
        if (r_state == ST_LOCK) begin
            w_grant = r_lock_idx;
            w_found = up_req_valid[r_lock_idx];
        end
    end

    // Downstream request path and upstream ready, all silenced in reset.
    always_comb begin
        up_req_ready = '0;
        dn_req_valid = rst_n & w_elig & w_found;
        dn_req_bits  = w_req_arr[w_grant];
        if (rst_n && w_elig && w_found && dn_req_ready) begin
            up_req_ready[w_grant] = 1'b1;
        end
    end

    // Response routing to the FIFO head channel; drain when nothing is owed.
    always_comb begin
        up_resp_valid = '0;
        dn_resp_ready = 1'b0;
        up_resp_bits  = dn_resp_bits;
        if (rst_n) begin
            if (!w_empty) begin
                up_resp_valid[w_head_ch] = dn_resp_valid;
                dn_resp_ready            = up_resp_ready[w_head_ch];
            end else begin
                dn_resp_ready = 1'b1;
            end
        end
    end

    assign w_push     = dn_req_valid & dn_req_ready;
    assign w_pop      = rst_n & dn_resp_valid & dn_resp_ready & ~w_empty;
    assign w_orphan   = dn_resp_valid & w_empty;
    assign w_lock_set = (r_state == ST_FREE) & dn_req_valid & ~dn_req_ready;

    // Lock FSM next state: hold the grant while the DM stalls a request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FREE: if (w_lock_set) w_state_nxt = ST_LOCK;
            ST_LOCK: if (w_push)     w_state_nxt = ST_FREE;
            default:                 w_state_nxt = ST_FREE;
        endcase
    end

    // Lock FSM state register and captured grant index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_FREE;
            r_lock_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_lock_set) begin
                r_lock_idx <= w_grant;
            end
        end
    end

    // Round-robin pointer advances past the channel just served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_push) begin
            r_rr_ptr <= (w_grant == IDX_W'(N_CH - 1)) ? '0 : w_grant + 1'b1;
        end
    end

    // ID FIFO storage; contents are meaningful only between head and tail.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_tail] <= w_grant;
        end
    end

    // ID FIFO pointers and occupancy; push and pop together leave it unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag for responses that arrive with nothing outstanding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_orphan) begin
            r_err <= 1'b1;
        end
    end

    assign outstanding     = r_count;
    assign err_orphan_resp = r_err;

endmodule

// File: tb/tb_dmi_mux_rr.sv
// Testbench for dmi_mux_rr: random multi-channel traffic against a DM model,
// with an in-order scoreboard for responses and a rule-level grant model.
module tb_dmi_mux_rr;

    localparam int unsigned N_CH    = 2;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 34;
    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned REQ_W   = ADDR_W + DATA_W + 2;
    localparam int unsigned RSP_W   = DATA_W + 2;
    localparam int unsigned TOT_W   = N_CH * REQ_W;
    localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N_CH-1:0]      up_req_valid;
    logic [N_CH-1:0]      up_req_ready;
    logic [TOT_W-1:0]     up_req_bits;
    logic [N_CH-1:0]      up_resp_valid;
    logic [N_CH-1:0]      up_resp_ready;
    logic [RSP_W-1:0]     up_resp_bits;
    logic                 dn_req_valid;
    logic                 dn_req_ready;
    logic [REQ_W-1:0]     dn_req_bits;
    logic                 dn_resp_valid;
    logic                 dn_resp_ready;
    logic [RSP_W-1:0]     dn_resp_bits;
    logic [CNT_W-1:0]     outstanding;
    logic                 err_orphan_resp;

    dmi_mux_rr #(
        .N_CH    (N_CH),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .up_req_valid    (up_req_valid),
        .up_req_ready    (up_req_ready),
        .up_req_bits     (up_req_bits),
        .up_resp_valid   (up_resp_valid),
        .up_resp_ready   (up_resp_ready),
        .up_resp_bits    (up_resp_bits),
        .dn_req_valid    (dn_req_valid),
        .dn_req_ready    (dn_req_ready),
        .dn_req_bits     (dn_req_bits),
        .dn_resp_valid   (dn_resp_valid),
        .dn_resp_ready   (dn_resp_ready),
        .dn_resp_bits    (dn_resp_bits),
        .outstanding     (outstanding),
        .err_orphan_resp (err_orphan_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned       ch;
        logic [RSP_W-1:0]  rsp;
    } exp_t;

    exp_t              sb_q[$];      // expected responses, in issue order
    logic [RSP_W-1:0]  dm_q[$];      // responses the DM model still owes
    int unsigned       n_vec = 0;
    int unsigned       n_err = 0;
    int unsigned       acc_cnt [N_CH];
    int unsigned       seen    [N_CH];
    logic              busy    [N_CH];
    logic [REQ_W-1:0]  sbits   [N_CH];

    // Reference model state: next search start, stalled-grant memory, error flag.
    int unsigned       m_next    = 0;
    logic              m_lock    = 1'b0;
    int unsigned       m_lock_ch = 0;
    logic              m_err     = 1'b0;

    function automatic logic chbit(input logic [N_CH-1:0] v, input int unsigned c);
        logic [N_CH-1:0] t;
        t = v >> c;
        return t[0];
    endfunction

    function automatic logic [REQ_W-1:0] req_of(input int unsigned c);
        logic [TOT_W-1:0] t;
        t = up_req_bits >> (c * REQ_W);
        return t[REQ_W-1:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against the model, then advances the model
    // with the handshakes that the coming clock edge will complete.
    always @(negedge clk) begin : mon
        int unsigned      g;
        int unsigned      c;
        logic             has;
        logic             exp_dv;
        logic             rsp_hs;
        logic [N_CH-1:0]  oh;
        logic [REQ_W-1:0] rq;

        chk("outstanding", 64'(outstanding), 64'(sb_q.size()));
        chk("err_orphan_resp", 64'(err_orphan_resp), 64'(m_err));

        if (!rst_n) begin
            chk("rst_up_req_ready",  64'(up_req_ready),  64'(0));
            chk("rst_dn_req_valid",  64'(dn_req_valid),  64'(0));
            chk("rst_up_resp_valid", 64'(up_resp_valid), 64'(0));
            chk("rst_dn_resp_ready", 64'(dn_resp_ready), 64'(0));
            sb_q.delete();
            dm_q.delete();
            m_next = 0;
            m_lock = 1'b0;
            m_err  = 1'b0;
        end else begin
            // Expected grant from the arbitration rules.
            has = 1'b0;
            g   = 0;
            if (m_lock) begin
                g   = m_lock_ch;
                has = chbit(up_req_valid, g);
            end else begin
                for (int unsigned k = 0; k < N_CH; k++) begin
                    c = (m_next + k) % N_CH;
                    if (!has && chbit(up_req_valid, c)) begin
                        has = 1'b1;
                        g   = c;
                    end
                end
            end
            exp_dv = has && (sb_q.size() < MAX_OUT);
            chk("dn_req_valid", 64'(dn_req_valid), 64'(exp_dv));
            oh = '0;
            if (exp_dv) begin
                rq = req_of(g);
                chk("dn_req_bits", 64'(dn_req_bits), 64'(rq));
                if (dn_req_ready) oh = N_CH'(1) << g;
            end
            chk("up_req_ready", 64'(up_req_ready), 64'(oh));

            // Response side.
            rsp_hs = 1'b0;
            if (dn_resp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("orphan_dn_resp_ready", 64'(dn_resp_ready), 64'(1));
                    chk("orphan_up_resp_valid", 64'(up_resp_valid), 64'(0));
                    m_err = 1'b1;
                end else begin
                    oh = N_CH'(1) << sb_q[0].ch;
                    chk("up_resp_valid", 64'(up_resp_valid), 64'(oh));
                    chk("dn_resp_ready", 64'(dn_resp_ready), 64'(chbit(up_resp_ready, sb_q[0].ch)));
                    rsp_hs = chbit(up_resp_ready, sb_q[0].ch);
                end
            end else begin
                chk("idle_up_resp_valid", 64'(up_resp_valid), 64'(0));
            end

            // Scoreboard: the channel the DUT delivers to, and the data, must
            // match the oldest outstanding request.
            if (rsp_hs) begin
                c = N_CH;
                for (int unsigned k = 0; k < N_CH; k++) begin
                    if (c == N_CH && chbit(up_resp_valid & up_resp_ready, k)) c = k;
                end
                chk("resp_channel", 64'(c), 64'(sb_q[0].ch));
                chk("resp_bits", 64'(up_resp_bits), 64'(sb_q[0].rsp));
                void'(sb_q.pop_front());
                void'(dm_q.pop_front());
            end

            // Request handshake: DM echoes the write data with a success code.
            if (exp_dv && dn_req_ready) begin
                exp_t e;
                e.ch  = g;
                e.rsp = {rq[DATA_W+1:2], 2'b00};
                sb_q.push_back(e);
                dm_q.push_back(e.rsp);
                acc_cnt[g] = acc_cnt[g] + 1;
                m_next = (g + 1) % N_CH;
                m_lock = 1'b0;
            end else if (exp_dv) begin
                m_lock    = 1'b1;
                m_lock_ch = g;
            end
        end
    end

    // Drive one cycle per iteration with the given percentages for new
    // source requests, DM request ready, DM response valid and upstream ready.
    task automatic run(input int unsigned ncyc, input int unsigned pv, input int unsigned pdr,
                       input int unsigned prv, input int unsigned prr, input logic [N_CH-1:0] en);
        logic [63:0]      rnd;
        logic [N_CH-1:0]  vb;
        logic [TOT_W-1:0] tb;
        for (int unsigned i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            vb = '0;
            tb = '0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (busy[c] && acc_cnt[c] != seen[c]) begin
                    busy[c] = 1'b0;
                    seen[c] = acc_cnt[c];
                end
                if (!busy[c] && chbit(en, c) && ($urandom % 100) < pv) begin
                    rnd      = {$urandom, $urandom};
                    sbits[c] = rnd[REQ_W-1:0];
                    busy[c]  = 1'b1;
                end
                vb = vb | (N_CH'(busy[c]) << c);
                tb = tb | (TOT_W'(sbits[c]) << (c * REQ_W));
            end
            up_req_valid = vb;
            up_req_bits  = tb;
            dn_req_ready = ($urandom % 100) < pdr;
            rnd = {$urandom, $urandom};
            if (dm_q.size() > 0 && ($urandom % 100) < prv) begin
                dn_resp_valid = 1'b1;
                dn_resp_bits  = dm_q[0];
            end else begin
                dn_resp_valid = 1'b0;
                dn_resp_bits  = rnd[RSP_W-1:0];
            end
            for (int unsigned c = 0; c < N_CH; c++) begin
                up_resp_ready[c] = ($urandom % 100) < prr;
            end
        end
    endtask

    task automatic clear_sources();
        for (int unsigned c = 0; c < N_CH; c++) begin
            busy[c] = 1'b0;
            seen[c] = acc_cnt[c];
        end
    endtask

    initial begin : stim
        logic [RSP_W-1:0] late;
        logic [63:0]      rnd;
        int unsigned      tries;

        rst_n         = 1'b0;
        up_req_valid  = '0;
        up_req_bits   = '0;
        up_resp_ready = '0;
        dn_req_ready  = 1'b0;
        dn_resp_valid = 1'b0;
        dn_resp_bits  = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            acc_cnt[c] = 0;
            seen[c]    = 0;
            busy[c]    = 1'b0;
            sbits[c]   = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single channel read of address 0x11, DM returns 0x2_0000_0001.
        busy[0]  = 1'b1;
        sbits[0] = {5'h11, 34'h2_0000_0001, 2'd1};
        run(6, 0, 100, 100, 100, '0);

        // Fairness: both channels always valid, DM always ready.
        run(20, 100, 100, 100, 100, '1);

        // Backpressure: DM stalls often, grants must stay locked.
        run(40, 100, 25, 100, 100, '1);

        // FIFO full: no responses, then responses resume.
        run(15, 100, 100, 0, 100, '1);
        run(15, 100, 100, 100, 100, '1);

        // Mixed random traffic.
        run(400, 60, 60, 60, 70, '1);

        // Reset with requests outstanding.
        tries = 0;
        while (sb_q.size() < 2 && tries < 50) begin
            run(1, 100, 100, 0, 100, '1);
            tries++;
        end
        n_vec++;
        if (dm_q.size() < 2) begin
            n_err++;
            $display("FAIL fill_before_reset: got %0d outstanding, expected at least 2", dm_q.size());
            late = '0;
        end else begin
            late = dm_q[0];
        end
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        dn_resp_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_sources();
        up_req_valid  = '0;
        dn_req_ready  = 1'b1;
        up_resp_ready = '1;
        dn_resp_valid = 1'b1;     // late DM response after reset
        dn_resp_bits  = late;

        // Both channels request after reset; ch0 must win.
        @(posedge clk);
        #1;
        dn_resp_valid = 1'b0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            rnd      = {$urandom, $urandom};
            sbits[c] = rnd[REQ_W-1:0];
            busy[c]  = 1'b1;
        end
        run(60, 60, 60, 60, 70, '1);

        // Final reset clears the sticky error.
        rst_n = 1'b0;
        run(2, 60, 60, 60, 70, '1);
        rst_n = 1'b1;
        run(10, 60, 60, 60, 70, '1);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmi_mux_rr.md
Name: dmi_mux_rr

Overview:
- N-channel DMI request multiplexer placed between several DTM-style request sources and one debug module DMI port.
- Intended sources: multiple JTAG DTMs, a sim-only backdoor driver and a second debugger transport.
- Arbitrates requests round-robin, tracks outstanding requests in an in-order ID FIFO, and routes each DM response back to the channel that issued it.
- Generalises the single-DTM/single-DM point-to-point DMI hookup to N_CH sources with bounded pipelining.

Parameters:
- N_CH, 2, number of upstream request channels (1..8).
- ADDR_W, 5, DMI address width.
- DATA_W, 34, DMI data width. Request width is ADDR_W+DATA_W+2 (41 at defaults); response width is DATA_W+2 (36 at defaults).
- MAX_OUT, 4, maximum outstanding (forwarded, not yet responded) requests; power of two, 1..16.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- up_req_valid  input  N_CH  per-channel request valid.
- up_req_ready  output  N_CH  per-channel request ready.
- up_req_bits  input  N_CH*(ADDR_W+DATA_W+2)  per-channel request {addr,data,op}; channel i at slice i.
- up_resp_valid  output  N_CH  per-channel response valid.
- up_resp_ready  input  N_CH  per-channel response ready.
- up_resp_bits  output  DATA_W+2  response {data,resp}, shared by all channels; qualified by up_resp_valid.
- dn_req_valid  output  1  request to DM.
- dn_req_ready  input  1  DM accepts request.
- dn_req_bits  output  ADDR_W+DATA_W+2  forwarded request.
- dn_resp_valid  input  1  DM response valid.
- dn_resp_ready  output  1  response accepted.
- dn_resp_bits  input  DATA_W+2  DM response.
- outstanding  output  $clog2(MAX_OUT+1)  current ID FIFO occupancy.
- err_orphan_resp  output  1  sticky flag: response received with no outstanding request.

Behaviour:
- Reset (rst_n low at clk edge):
  - RR pointer = 0, lock = 0, ID FIFO empty, outstanding = 0, err_orphan_resp = 0.
  - While rst_n is low, all ready/valid outputs are 0.
  - Reset mid-transaction drops all pending IDs; late DM responses after reset raise err_orphan_resp.
- Request arbitration (combinational grant, zero-cycle forward):
  - Eligible when ID FIFO not full (outstanding < MAX_OUT).
  - Grant goes to the first channel with up_req_valid set, searching from rr_ptr upward modulo N_CH.
  - dn_req_valid = eligible & any granted valid; dn_req_bits = granted channel bits.
  - up_req_ready[g] = eligible & dn_req_ready for the granted channel g only; all other bits are 0.
- Grant lock:
  - If dn_req_valid=1 and dn_req_ready=0, lock=1 and the locked grant index is held next cycle regardless of other channels.
  - Upstream sources must hold valid/bits stable, so dn_req_bits stays stable.
  - Lock clears on handshake.
- On a request handshake:
  - Push grant index into the ID FIFO.
  - rr_ptr <= (g+1) mod N_CH.
- Full ID FIFO:
  - Blocks all forwarding, even if a response pop occurs in the same cycle; the push is permitted the following cycle.
  - dn_req_valid drops only when not locked. Lock cannot be set while full, because eligibility is evaluated before the lock is set.
- Response routing:
  - FIFO head h selects the channel: up_resp_valid[h] = dn_resp_valid & !empty; up_resp_bits = dn_resp_bits.
  - dn_resp_ready = up_resp_ready[h] when not empty.
  - Pop on handshake. Responses are in order; the DM returns responses in issue order.
- Empty FIFO with dn_resp_valid:
  - dn_resp_ready = 1 (drain); no up_resp_valid.
  - err_orphan_resp <= 1, sticky until reset.
- Simultaneous push and pop (not full): occupancy is unchanged; head/tail pointers wrap modulo MAX_OUT.
- N_CH=1 degenerates to a pass-through with outstanding limiting.

Test Plan:
- Single channel: ch0 read addr 0x11 → dn_req_bits forwarded same cycle; outstanding=1; DM response data 0x2_0000_0001 is returned on ch0 only; outstanding=0.
- Fairness: ch0 and ch1 held valid continuously, dn_req_ready=1 → grants alternate 0,1,0,1; all responses are returned to the correct channel in order.
- Backpressure lock: ch1 granted with dn_req_ready=0 for 3 cycles while ch0 asserts valid → dn_req_bits stays ch1 for all 3 cycles; after the handshake the next grant is ch0.
- FIFO full: MAX_OUT=4, 4 requests forwarded with no response → dn_req_valid=0 and up_req_ready=0; one response popped → a forward occurs in the next cycle, not the same cycle.
- Orphan response: after reset, dn_resp_valid pulsed with empty FIFO → dn_resp_ready=1, no up_resp_valid, err_orphan_resp=1 until rst_n low.
- Reset mid-operation: 2 outstanding, then rst_n low for 1 cycle → outstanding=0 and all outputs 0; a subsequent new request is granted to ch0 (rr_ptr=0).
